// File: rtl/adder_tree_pipe.sv
// Pipelined N-input adder tree with one register stage per tree level and valid/ready flow control.
// Optional sign handling and output saturation applied in the final stage.
module adder_tree_pipe #(
  parameter int BITS   = 16,
  parameter int NUM    = 4,
  parameter int SIGNED = 0,
  parameter int SAT    = 0,
  localparam int LEVELS = $clog2(NUM),
  localparam int OBITS  = (SAT != 0) ? BITS : BITS + LEVELS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid,
  output logic                  ready,
  input  logic [NUM*BITS-1:0]   i,
  output logic [OBITS-1:0]      o,
  output logic                  valid_out,
  input  logic                  ready_out
);

  localparam int FW = BITS + LEVELS;
  localparam int NE = 2 * NUM;
  localparam logic [FW-1:0] ONE  = FW'(1);
  localparam logic [FW-1:0] UMAX = (ONE << BITS) - ONE;
  localparam logic [FW-1:0] SMAX = (ONE << (BITS - 1)) - ONE;
  localparam logic [FW-1:0] SMIN = ~SMAX;

  logic [LEVELS-1:0] vld_q, vld_d;
  logic [LEVELS-1:0] cap;
  logic [LEVELS:0]   vin;
  logic [FW-1:0]     lvl_q [LEVELS][NUM];
  logic [FW-1:0]     lvl_d [LEVELS][NUM];
  logic [FW-1:0]     node  [LEVELS][NE];

  function automatic int cnt(input int l);
    return (NUM + (1 << l) - 1) >> l;
  endfunction

  function automatic logic [FW-1:0] ext(input logic [BITS-1:0] x);
    logic [FW-1:0] y;
    if (SIGNED != 0) y = {{LEVELS{x[BITS-1]}}, x};
    else             y = {{LEVELS{1'b0}}, x};
    return y;
  endfunction

  // Full-width final sum reduced to the output range; identity when SAT=0.
  function automatic logic [OBITS-1:0] sat_fn(input logic [FW-1:0] x);
    logic signed [FW-1:0] sx;
    logic [OBITS-1:0]     y;
    sx = signed'(x);
    y  = x[OBITS-1:0];
    if (SAT != 0) begin
      if (SIGNED != 0) begin
        if (sx > signed'(SMAX))      y = OBITS'(SMAX);
        else if (sx < signed'(SMIN)) y = OBITS'(SMIN);
      end else if (x > UMAX) begin
        y = OBITS'(UMAX);
      end
    end
    return y;
  endfunction

  // Tree node view: level 0 is the extended inputs, level l>0 is stage l-1's register.
  // Entries past a level's count stay zero, so an odd trailing entry plus zero is a pass-through.
  always_comb begin
    node = '{default: '0};
    for (int k = 0; k < NUM; k++) node[0][k] = ext(i[k*BITS +: BITS]);
    for (int l = 1; l < LEVELS; l++)
      for (int j = 0; j < NUM; j++) node[l][j] = lvl_q[l-1][j];
  end

  always_comb begin
    logic [FW-1:0] sum;
    sum   = '0;
    cap   = '0;
    vin   = {vld_q, valid};
    vld_d = vld_q;
    lvl_d = lvl_q;
    cap[LEVELS-1] = !vld_q[LEVELS-1] || ready_out;
    for (int s = LEVELS - 2; s >= 0; s--) cap[s] = !vld_q[s] || cap[s+1];
    for (int s = 0; s < LEVELS; s++) begin
      if (cap[s]) vld_d[s] = vin[s];
      if (cap[s] && vin[s]) begin
        for (int j = 0; j < NUM; j++) begin
          sum = (j < cnt(s + 1)) ? node[s][2*j] + node[s][2*j+1] : '0;
          if (s == LEVELS - 1) lvl_d[s][j] = FW'(sat_fn(sum));
          else                 lvl_d[s][j] = sum;
        end
      end
    end
  end

  // Stage registers: one per tree level, the last one holds the (clamped) result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      lvl_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      lvl_q <= lvl_d;
    end
  end

  assign ready     = cap[0];
  assign valid_out = vld_q[LEVELS-1];
  assign o         = lvl_q[LEVELS-1][0][OBITS-1:0];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe across five parameter sets sharing clock and reset.
module tb_adder_tree_pipe;

  localparam int NI = 5;
  localparam int NUMS [NI] = '{4, 5, 4, 8, 7};
  localparam int SG   [NI] = '{0, 0, 1, 0, 1};
  localparam int SA   [NI] = '{0, 0, 1, 0, 0};
  localparam int LV   [NI] = '{2, 3, 2, 3, 3};
  localparam int OB   [NI] = '{18, 19, 16, 19, 19};

  typedef struct {
    logic [63:0] v;
    int          cyc;
    bit          lat;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic [NI-1:0] vld;
  logic [NI-1:0] rout_fix;
  logic [NI-1:0] rrand;
  logic [NI-1:0] rand_bits;
  wire  [NI-1:0] rout;
  wire  [NI-1:0] rdy;
  wire  [NI-1:0] vout;
  logic [127:0]  ibus [NI];
  logic [63:0]   o64  [NI];
  wire  [17:0]   o0;
  wire  [18:0]   o1;
  wire  [15:0]   o2;
  wire  [18:0]   o3;
  wire  [18:0]   o4;

  exp_t sbq [NI][$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  assign rout = (rrand & rand_bits) | (~rrand & rout_fix);
  assign o64[0] = 64'(o0);
  assign o64[1] = 64'(o1);
  assign o64[2] = 64'(o2);
  assign o64[3] = 64'(o3);
  assign o64[4] = 64'(o4);

  adder_tree_pipe #(.BITS(16), .NUM(4), .SIGNED(0), .SAT(0)) u0 (
    .clk(clk), .resetn(resetn), .valid(vld[0]), .ready(rdy[0]), .i(ibus[0][63:0]),
    .o(o0), .valid_out(vout[0]), .ready_out(rout[0]));
  adder_tree_pipe #(.BITS(16), .NUM(5), .SIGNED(0), .SAT(0)) u1 (
    .clk(clk), .resetn(resetn), .valid(vld[1]), .ready(rdy[1]), .i(ibus[1][79:0]),
    .o(o1), .valid_out(vout[1]), .ready_out(rout[1]));
  adder_tree_pipe #(.BITS(16), .NUM(4), .SIGNED(1), .SAT(1)) u2 (
    .clk(clk), .resetn(resetn), .valid(vld[2]), .ready(rdy[2]), .i(ibus[2][63:0]),
    .o(o2), .valid_out(vout[2]), .ready_out(rout[2]));
  adder_tree_pipe #(.BITS(16), .NUM(8), .SIGNED(0), .SAT(0)) u3 (
    .clk(clk), .resetn(resetn), .valid(vld[3]), .ready(rdy[3]), .i(ibus[3][127:0]),
    .o(o3), .valid_out(vout[3]), .ready_out(rout[3]));
  adder_tree_pipe #(.BITS(16), .NUM(7), .SIGNED(1), .SAT(0)) u4 (
    .clk(clk), .resetn(resetn), .valid(vld[4]), .ready(rdy[4]), .i(ibus[4][111:0]),
    .o(o4), .valid_out(vout[4]), .ready_out(rout[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rand_bits = '0;
    forever begin
      @(negedge clk);
      rand_bits = NI'($urandom);
    end
  end

  // Reference: plain integer sum of the operands, then clamp or mask to the output width.
  function automatic logic [63:0] model(input int idx, input logic [15:0] ops [8]);
    longint s;
    s = 0;
    for (int k = 0; k < NUMS[idx]; k++)
      s += (SG[idx] != 0) ? longint'($signed(ops[k])) : longint'(ops[k]);
    if (SA[idx] != 0) begin
      if (SG[idx] != 0) begin
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
      end else if (s > 65535) begin
        s = 65535;
      end
    end
    return 64'(s) & ((64'd1 << OB[idx]) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic rand_ops(output logic [15:0] ops [8]);
    for (int k = 0; k < 8; k++) ops[k] = 16'($urandom);
  endtask

  task automatic pack(input int idx, input logic [15:0] ops [8]);
    ibus[idx] = '0;
    for (int k = 0; k < NUMS[idx]; k++) ibus[idx][k*16 +: 16] = ops[k];
  endtask

  task automatic push(input int idx, input logic [15:0] ops [8], input bit lat);
    exp_t e;
    e.v   = model(idx, ops);
    e.cyc = cyc;
    e.lat = lat;
    sbq[idx].push_back(e);
  endtask

  task automatic send(input int idx, input logic [15:0] ops [8], input bit lat);
    int g;
    @(negedge clk);
    pack(idx, ops);
    vld[idx] = 1'b1;
    #1;
    g = 0;
    while (!rdy[idx] && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!rdy[idx]) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout inst %0d: ready stayed 0, required 1", idx);
    end else begin
      push(idx, ops, lat);
      @(posedge clk);
    end
    #1 vld[idx] = 1'b0;
  endtask

  task automatic drain(input int idx);
    int g;
    g = 0;
    while (sbq[idx].size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    #3;
    chk($sformatf("drain_%0d", idx), 64'(sbq[idx].size()), 64'd0);
  endtask

  // Monitor: pops on every output transfer, checks order, latency and stall stability.
  initial begin
    logic          held  [NI];
    logic [63:0]   hold_o[NI];
    exp_t          e;
    for (int k = 0; k < NI; k++) begin
      held[k]   = 1'b0;
      hold_o[k] = '0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < NI; k++) begin
        if (!resetn) begin
          held[k] = 1'b0;
        end else begin
          if (held[k]) begin
            chk($sformatf("stall_vout_%0d", k), 64'(vout[k]), 64'd1);
            chk($sformatf("stall_hold_%0d", k), o64[k], hold_o[k]);
          end
          if (vout[k] && rout[k]) begin
            if (sbq[k].size() == 0) begin
              nchk++;
              nerr++;
              $display("FAIL unexpected_out inst %0d: got o=%0h with nothing outstanding, required no output", k, o64[k]);
            end else begin
              e = sbq[k].pop_front();
              chk($sformatf("sum_%0d", k), o64[k], e.v);
              if (e.lat) chk($sformatf("latency_%0d", k), 64'(cyc - e.cyc), 64'(LV[k]));
            end
          end
          held[k]   = vout[k] && !rout[k];
          hold_o[k] = o64[k];
        end
      end
    end
  end

  initial begin
    logic [15:0] ops [8];
    int acc;
    resetn   = 1'b0;
    vld      = '0;
    rout_fix = '0;
    rrand    = '0;
    for (int k = 0; k < NI; k++) ibus[k] = '0;

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_vout_%0d", k), 64'(vout[k]), 64'd0);
      chk($sformatf("rst_o_%0d", k), o64[k], 64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) chk($sformatf("rst_ready_%0d", k), 64'(rdy[k]), 64'd1);
    rout_fix = '1;

    // NUM=4 unsigned: {4,3,2,1}
    for (int k = 0; k < 8; k++) ops[k] = (k < 4) ? 16'(k + 1) : 16'd0;
    send(0, ops, 1'b1);
    drain(0);

    // NUM=5 unsigned: all-ones, then 20 back-to-back random vectors
    for (int k = 0; k < 8; k++) ops[k] = 16'hFFFF;
    send(1, ops, 1'b1);
    drain(1);
    for (int n = 0; n < 20; n++) begin
      rand_ops(ops);
      send(1, ops, 1'b1);
    end
    drain(1);

    // NUM=4 signed saturating corner cases
    for (int k = 0; k < 8; k++) ops[k] = 16'h7FFF;
    send(2, ops, 1'b1);
    for (int k = 0; k < 8; k++) ops[k] = 16'h8000;
    send(2, ops, 1'b1);
    ops[0] = 16'h7FFF; ops[1] = 16'h8000; ops[2] = 16'd5; ops[3] = 16'hFFFD;
    send(2, ops, 1'b1);
    for (int n = 0; n < 10; n++) begin
      rand_ops(ops);
      send(2, ops, 1'b1);
    end
    drain(2);

    // NUM=8 backpressure: fill with output stalled, then release
    rout_fix[3] = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rand_ops(ops);
      pack(3, ops);
      vld[3] = 1'b1;
      #1;
      if (rdy[3]) begin
        push(3, ops, 1'b0);
        acc++;
      end
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_ready_low", 64'(rdy[3]), 64'd0);
    chk("bp_vout", 64'(vout[3]), 64'd1);
    if (sbq[3].size() != 0) chk("bp_hold_first", o64[3], sbq[3][0].v);
    @(negedge clk);
    rout_fix[3] = 1'b1;
    #1;
    chk("bp_ready_back", 64'(rdy[3]), 64'd1);
    push(3, ops, 1'b0);
    @(posedge clk);
    #1 vld[3] = 1'b0;
    drain(3);

    // NUM=7 signed: random valid gaps and random ready_out
    rrand[4] = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      rand_ops(ops);
      send(4, ops, 1'b0);
    end
    rrand[4]    = 1'b0;
    rout_fix[4] = 1'b1;
    drain(4);

    // Reset with two vectors in flight
    rout_fix[4] = 1'b0;
    rand_ops(ops);
    send(4, ops, 1'b0);
    rand_ops(ops);
    send(4, ops, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pre_vout", 64'(vout[4]), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_vout", 64'(vout[4]), 64'd0);
    chk("rst_async_o", o64[4], 64'd0);
    sbq[4].delete();
    @(negedge clk);
    resetn      = 1'b1;
    rout_fix[4] = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_spurious", 64'(vout[4]), 64'd0);
    rand_ops(ops);
    send(4, ops, 1'b1);
    drain(4);

    for (int k = 0; k < NI; k++) chk($sformatf("final_empty_%0d", k), 64'(sbq[k].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, fully pipelined N-input adder tree; next generation of the fixed two-level num=4 adder.
- Supports any input count from 2 to 32, signed or unsigned operands, and width-growth or saturating output.
- Adds valid/ready backpressure with one register stage per tree level.
- Used wherever a datapath reduces a vector of lanes to one sum at one transaction per cycle.

Parameters:
- BITS, 16: operand width.
- NUM, 4: number of operands, 2..32.
- SIGNED, 0: 1 = operands and result are two's complement; 0 = unsigned.
- SAT, 0: 0 = output width BITS+LEVELS, exact result; 1 = output width BITS, clamped to the representable range.
- LEVELS (derived), ceil(log2(NUM)): number of tree levels, which equals the latency.
- OBITS (derived): SAT ? BITS : BITS+LEVELS.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- valid  input  1  input vector valid.
- ready  output  1  block accepts the input vector this cycle.
- i  input  NUM*BITS  packed operands; operand k = i[k*BITS +: BITS].
- o  output  OBITS  sum.
- valid_out  output  1  o valid.
- ready_out  input  1  downstream accepts o.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (resetn).
- Reset values: all stage valid bits 0, so valid_out=0. ready=1 once resetn is high. Data registers reset to 0, so o=0.
- Tree structure:
  - Level L (1..LEVELS) pairs adjacent entries of level L-1: entry j = e[2j] + e[2j+1].
  - An odd trailing entry passes through unchanged, extended by one bit.
  - Level 0 is the input operands.
  - Each level is registered.
- Widths:
  - Level L entries are BITS+L bits wide, so no intermediate overflow is possible.
  - Extension is sign extension if SIGNED=1, zero extension if SIGNED=0.
- Handshake:
  - Transfer in when valid & ready. Transfer out when valid_out & ready_out.
  - Stage s captures when its valid bit v[s]=0 or stage s+1 captures this cycle. The last stage's successor is the output transfer.
  - ready = capture condition of stage 1.
  - Bubbles collapse: a stalled output does not block upstream stages that are empty.
  - Throughput is 1 vector/cycle while ready_out=1.
  - Latency is exactly LEVELS cycles from the input transfer to valid_out with no stall. NUM=2 gives 1 cycle.
- Stall: while valid_out=1 and ready_out=0, o and valid_out hold stable. At most LEVELS vectors are in flight; none are dropped or duplicated.
- Simultaneous events: an output transfer and an input transfer in the same cycle, with all stages full, is legal. ready stays 1 and the pipe shifts.
- Saturation (SAT=1): applied only to the final level's full-width sum.
  - SIGNED=1: clamp to [-2^(BITS-1), 2^(BITS-1)-1].
  - SIGNED=0: clamp to [0, 2^BITS-1].
  - Intermediate levels never saturate.
  - The clamp is registered in the last stage, so it adds no extra latency.
- The input i is sampled only on an input transfer. Changing i while ready=0 has no effect.
- Reset mid-operation: all in-flight vectors are discarded immediately. valid_out drops to 0 asynchronously. No output follows the release of resetn until a new input transfer.
- The pipe is order preserving: outputs leave in input order.

Test Plan:
- NUM=4, BITS=16, unsigned, SAT=0: send i={4,3,2,1}, ready_out=1 -> valid_out high exactly 2 cycles later, o=18'd10.
- NUM=5, unsigned: send operands 0xFFFF x5 -> 3-cycle latency, o=19'h4FFFB. Then 20 back-to-back vectors of random operands -> 20 outputs on 20 consecutive cycles, matching a reference model.
- NUM=4, SIGNED=1, SAT=1: send 0x7FFF x4 -> o=0x7FFF. Send 0x8000 x4 -> o=0x8000. Send {0x7FFF,0x8000,5,-3} -> o=0x0001.
- Backpressure at NUM=8 (3 stages):
  - Stream inputs with ready_out=0 -> exactly 3 input transfers accepted, then ready=0. o holds the first sum.
  - Raise ready_out -> all 3 sums are delivered in order, and ready returns to 1 in the same cycle as the first output transfer.
- Random valid/ready_out toggling, 1000 vectors, NUM=7, SIGNED=1, SAT=0 -> scoreboard shows no loss, no duplication, order preserved, and o stable during stalls.
- Reset mid-operation: assert resetn=0 with 2 vectors in flight -> valid_out=0 within the same cycle. After release, no output appears until new input; the next vector's sum is correct.
